// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencing controller.
//   pipe_state_e    : controller states (RUN / LSTALL / BWAIT)
//   ZeroReg         : x0 register address
//   ZeroWord        : 32-bit zero
//   load_use_hazard : EX load writing a register the decoder is reading
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    BWAIT  = 2'd2
  } pipe_state_e;

  localparam logic [4:0]  ZeroReg  = '0;
  localparam logic [31:0] ZeroWord = '0;

  function automatic logic load_use_hazard(input logic       ex_load,
                                           input logic [4:0] ex_rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return ex_load && (ex_rd != ZeroReg) && ((ex_rd == rs1) || (ex_rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_bus_timer.sv
// pipe_bus_timer: 8-bit clear/enable timer with terminal-count pulse.
//   clk, rst : clock, asynchronous active-low reset
//   clr_i    : synchronous clear (dominates enable)
//   en_i     : count one held cycle
//   tc_o     : high in the enabled cycle that would be the TERM-th count
module pipe_bus_timer #(
  parameter int unsigned TERM = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == 8'(TERM - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller (pc / if_id / id_ex hold & flush).
//   clk, rst                 : clock, asynchronous active-low reset
//   jump_flag_i/jump_addr_i  : EX redirect request and target
//   ex_load_i, ex_rd_i       : EX load and its destination register
//   id_reg{1,2}_raddr_i      : decoder source register addresses
//   bus_req_i, bus_ack_i     : EX data-bus access outstanding / completing
//   hold_*_o, flush_*_o      : pipeline register controls
//   jump_flag_o/jump_addr_o  : pc redirect
//   bus_err_o                : one-cycle bus timeout pulse
// Optional feature: define PIPE_CTRL_BUS_TIMEOUT_EN to abandon a bus wait
// after BUS_TIMEOUT held cycles; otherwise BWAIT waits indefinitely.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned BUS_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [4:0]  id_reg1_raddr_i,
  input  logic [4:0]  id_reg2_raddr_i,
  input  logic        bus_req_i,
  input  logic        bus_ack_i,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        bus_err_o
);

  if (LOAD_STALL_CYC < 1 || LOAD_STALL_CYC > 3 ||
      BUS_TIMEOUT < 1 || BUS_TIMEOUT > 255) begin : g_param_check
    $error("pipe_ctrl: parameter out of range");
  end

  pipe_state_e state_q, state_d;
  logic [1:0]  stall_cnt_q, stall_cnt_d;

  logic        load_use;
  logic        eval_run;
  logic        timeout;

  logic        hold_pc, hold_if_id, hold_id_ex;
  logic        flush_if_id, flush_id_ex;
  logic        jump_flag, bus_err;
  logic [31:0] jump_addr;

`ifdef PIPE_CTRL_BUS_TIMEOUT_EN
  pipe_bus_timer #(
    .TERM (BUS_TIMEOUT)
  ) u_bus_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != BWAIT),
    .en_i  ((state_q == BWAIT) && !bus_ack_i),
    .tc_o  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign load_use = load_use_hazard(ex_load_i, ex_rd_i, id_reg1_raddr_i, id_reg2_raddr_i);

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    eval_run    = 1'b0;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    hold_id_ex  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jump_flag   = 1'b0;
    jump_addr   = ZeroWord;
    bus_err     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus_req_i && !bus_ack_i) begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          state_d    = BWAIT;
        end else begin
          eval_run = 1'b1;
        end
      end
      LSTALL: begin
        if (jump_flag_i) begin
          jump_flag   = 1'b1;
          jump_addr   = jump_addr_i;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          stall_cnt_d = '0;
          state_d     = RUN;
        end else begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
          if (stall_cnt_q == 2'd1) begin
            stall_cnt_d = '0;
            state_d     = RUN;
          end else begin
            stall_cnt_d = stall_cnt_q - 2'd1;
          end
        end
      end
      BWAIT: begin
        if (bus_ack_i) begin
          eval_run = 1'b1;
          state_d  = RUN;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = RUN;
        end else begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
        end
      end
      default: begin
        state_d     = RUN;
        stall_cnt_d = '0;
      end
    endcase

    // RUN items 2-3, shared by plain RUN and the BWAIT ack cycle.
    if (eval_run) begin
      if (jump_flag_i) begin
        jump_flag   = 1'b1;
        jump_addr   = jump_addr_i;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        hold_pc     = 1'b1;
        hold_if_id  = 1'b1;
        flush_id_ex = 1'b1;
        if (LOAD_STALL_CYC > 1) begin
          stall_cnt_d = 2'(LOAD_STALL_CYC - 1);
          state_d     = LSTALL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are combinational, so reset gates them directly to drop at once.
  always_comb begin
    hold_pc_o     = rst & hold_pc;
    hold_if_id_o  = rst & hold_if_id;
    hold_id_ex_o  = rst & hold_id_ex;
    flush_if_id_o = rst & flush_if_id;
    flush_id_ex_o = rst & flush_id_ex;
    jump_flag_o   = rst & jump_flag;
    jump_addr_o   = rst ? jump_addr : ZeroWord;
    bus_err_o     = rst & bus_err;
  end

endmodule
